pe_stream_driver: RTL and testbench

// - Initiator side of the PE's valid/ready streams. It drives config, filter, ifmap and

---
 rtl/pe_stream_driver.sv | 175 +++++++++++++++++
 tb/tb_pe_stream_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_driver.sv
// pe_stream_driver: GLB-to-PE stream initiator (config, filter, ifmap, ipsum out; opsum back to buffer).
// Optional stall counter output stall_cnt enabled by defining PE_DRV_PERF_EN.
module pe_stream_driver #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CFG_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg,
  input  logic [ADDR_W-1:0] filter_base,
  input  logic [ADDR_W-1:0] ifmap_base,
  input  logic [ADDR_W-1:0] ipsum_base,
  input  logic [ADDR_W-1:0] opsum_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              pe_en,
  output logic [CFG_W-1:0]  pe_config,
  output logic [DATA_W-1:0] filter,
  output logic              filter_valid,
  input  logic              filter_ready,
  output logic [DATA_W-1:0] ifmap,
  output logic              ifmap_valid,
  input  logic              ifmap_ready,
  output logic [DATA_W-1:0] depthwise_ipsum,
  output logic              depthwise_ipsum_valid,
  input  logic              depthwise_ipsum_ready,
  output logic [DATA_W-1:0] pointwise_ipsum,
  output logic              pointwise_ipsum_valid,
  input  logic              pointwise_ipsum_ready,
  input  logic [DATA_W-1:0] opsum,
  input  logic              opsum_valid,
  output logic              opsum_ready
`ifdef PE_DRV_PERF_EN
  , output logic [31:0]     stall_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, CFG, FILTER, IFMAP, DW_IPSUM, PW_IPSUM, OPSUM, DONE} state_t;
  state_t state_q, state_d, nxt;
  logic phase_q, phase_d, fresh_q, fresh_d;
  logic [DATA_W-1:0] data_q, data_d, word;
  logic [7:0] word_q, word_d, target, p_n, q_n, rs_n;
  logic [4:0] col_q, col_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [ADDR_W-1:0] filt_q, filt_d, ifm_q, ifm_d, ips_q, ips_d, obase_q, obase_d, out_q, out_d;
  logic dw, send, ready_cur, last;
  assign dw = cfg_q[12];
  assign p_n = 8'(cfg_q[8:7]) + 8'd1;
  assign q_n = 8'(cfg_q[1:0]) + 8'd1;
  assign rs_n = 8'(cfg_q[11:10]) + 8'd1;
  assign send = state_q inside {FILTER, IFMAP, DW_IPSUM, PW_IPSUM};
  assign ready_cur = state_q == FILTER ? filter_ready : state_q == IFMAP ? ifmap_ready :
                     state_q == DW_IPSUM ? depthwise_ipsum_ready : pointwise_ipsum_ready;
  assign target = state_q == FILTER ? p_n * rs_n : state_q == IFMAP ? (col_q == 5'd0 ? rs_n : 8'd1) :
                  state_q == PW_IPSUM ? p_n : dw ? q_n : p_n;
  assign last = word_q + 8'd1 == target;
  assign nxt = state_q == FILTER ? IFMAP : state_q == IFMAP ? DW_IPSUM :
               (state_q == DW_IPSUM && dw) ? PW_IPSUM : OPSUM;
  // In the first HOLD cycle the word is still on rd_data; afterwards it comes from data_q
  assign word = fresh_q ? rd_data : data_q;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fresh_d = 1'b0;
    data_d  = word;
    word_d  = word_q;
    col_d   = col_q;
    cfg_d   = cfg_q;
    filt_d  = filt_q;
    ifm_d   = ifm_q;
    ips_d   = ips_q;
    obase_d = obase_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CFG;
        cfg_d   = cfg;
        filt_d  = filter_base;
        ifm_d   = ifmap_base;
        ips_d   = ipsum_base;
        obase_d = opsum_base;
        out_d   = '0;
        word_d  = '0;
        col_d   = '0;
        phase_d = 1'b0;
      end
      CFG: state_d = FILTER;
      OPSUM: if (opsum_valid) begin
        out_d  = out_q + ADDR_W'(1);
        word_d = last ? '0 : word_q + 8'd1;
        if (last) begin
          state_d = col_q == cfg_q[6:2] ? DONE : IFMAP;
          col_d   = col_q + 5'd1;
        end
      end
      DONE: state_d = IDLE;
      default: if (!phase_q) begin
        phase_d = 1'b1;
        fresh_d = 1'b1;
        filt_d  = state_q == FILTER ? filt_q + ADDR_W'(1) : filt_q;
        ifm_d   = state_q == IFMAP ? ifm_q + ADDR_W'(1) : ifm_q;
        ips_d   = state_q inside {DW_IPSUM, PW_IPSUM} ? ips_q + ADDR_W'(1) : ips_q;
      end else if (ready_cur) begin
        phase_d = 1'b0;
        word_d  = last ? '0 : word_q + 8'd1;
        state_d = last ? nxt : state_q;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      fresh_q <= 1'b0;
      data_q  <= '0;
      word_q  <= '0;
      col_q   <= '0;
      cfg_q   <= '0;
      filt_q  <= '0;
      ifm_q   <= '0;
      ips_q   <= '0;
      obase_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      fresh_q <= fresh_d;
      data_q  <= data_d;
      word_q  <= word_d;
      col_q   <= col_d;
      cfg_q   <= cfg_d;
      filt_q  <= filt_d;
      ifm_q   <= ifm_d;
      ips_q   <= ips_d;
      obase_q <= obase_d;
      out_q   <= out_d;
    end
  end
  assign busy = !(state_q inside {IDLE, DONE});
  assign done = state_q == DONE;
  assign pe_en = state_q == CFG;
  assign pe_config = pe_en ? cfg_q : '0;
  assign rd_en = send && !phase_q;
  assign rd_addr = !rd_en ? '0 : state_q == FILTER ? filt_q : state_q == IFMAP ? ifm_q : ips_q;
  assign opsum_ready = state_q == OPSUM;
  assign wr_en = opsum_ready && opsum_valid;
  assign wr_addr = obase_q + out_q;
  assign wr_data = wr_en ? opsum : '0;
  assign filter = word;
  assign ifmap = word;
  assign depthwise_ipsum = word;
  assign pointwise_ipsum = word;
  assign filter_valid = phase_q && state_q == FILTER;
  assign ifmap_valid = phase_q && state_q == IFMAP;
  assign depthwise_ipsum_valid = phase_q && state_q == DW_IPSUM;
  assign pointwise_ipsum_valid = phase_q && state_q == PW_IPSUM;
`ifdef PE_DRV_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic stall_inc;
  assign stall_inc = (send && phase_q && !ready_cur) || (state_q == OPSUM && !opsum_valid);
  always_comb stall_d = (state_q == IDLE && start) ? '0 : stall_q + 32'(stall_inc);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_pe_stream_driver.sv
// tb_pe_stream_driver: scoreboard bench for pe_stream_driver; expected stream words and writes are queued at launch.
module tb_pe_stream_driver;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [12:0] cfg = '0;
  logic [15:0] filter_base = '0, ifmap_base = '0, ipsum_base = '0, opsum_base = '0;
  logic busy, done, rd_en, wr_en, pe_en;
  logic [15:0] rd_addr, wr_addr;
  logic [31:0] rd_data = '0, wr_data, filter, ifmap, depthwise_ipsum, pointwise_ipsum, opsum = '0;
  logic [12:0] pe_config;
  logic filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid, opsum_ready;
  logic filter_ready = 1'b1, ifmap_ready = 1'b1, depthwise_ipsum_ready = 1'b1, pointwise_ipsum_ready = 1'b1;
  logic opsum_valid = 1'b1;
`ifdef PE_DRV_PERF_EN
  logic [31:0] stall_cnt;
`endif
  pe_stream_driver dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg),
    .filter_base(filter_base), .ifmap_base(ifmap_base), .ipsum_base(ipsum_base), .opsum_base(opsum_base),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pe_en(pe_en), .pe_config(pe_config),
    .filter(filter), .filter_valid(filter_valid), .filter_ready(filter_ready),
    .ifmap(ifmap), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
    .depthwise_ipsum(depthwise_ipsum), .depthwise_ipsum_valid(depthwise_ipsum_valid),
    .depthwise_ipsum_ready(depthwise_ipsum_ready),
    .pointwise_ipsum(pointwise_ipsum), .pointwise_ipsum_valid(pointwise_ipsum_valid),
    .pointwise_ipsum_ready(pointwise_ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
`ifdef PE_DRV_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int k; logic [31:0] d; logic [15:0] a;} ev_t;
  ev_t sb[$];
  int vecs = 0, errs = 0;
  int n_fhs, n_ihs, n_wr, n_rd, n_done, n_fv;
  int ok_k = 0, ov_mode = 0;
  localparam logic [12:0] CA = {1'b0, 2'd2, 1'b0, 2'd1, 5'd0, 2'd3};
  localparam logic [12:0] CB = {1'b1, 2'd0, 1'b0, 2'd3, 5'd7, 2'd0};
  localparam logic [12:0] CD = {1'b1, 2'd2, 1'b0, 2'd0, 5'd1, 2'd3};
  localparam logic [12:0] CE = {1'b0, 2'd0, 1'b0, 2'd2, 5'd0, 2'd0};
  function automatic logic [31:0] mem_f(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input int k, input logic [31:0] d, input logic [15:0] a);
    ev_t e;
    e.k = k; e.d = d; e.a = a;
    sb.push_back(e);
  endtask
  task automatic see(input int k, input logic [31:0] d, input logic [15:0] a);
    ev_t e;
    if (sb.size() == 0) begin
      vecs++; errs++;
      $display("FAIL unexpected event kind %0d data %h addr %h, expected none", k, d, a);
    end else begin
      e = sb.pop_front();
      chk($sformatf("event_kind%0d", e.k), {8'(k), d, a}, {8'(e.k), e.d, e.a});
    end
  endtask
  task automatic gen(input logic [12:0] c, input logic [15:0] fb, ib, pb, ob);
    int p, q, rs, cols;
    logic [15:0] fa, ia, pa, oa;
    p = int'(c[8:7]) + 1; q = int'(c[1:0]) + 1; rs = int'(c[11:10]) + 1; cols = int'(c[6:2]) + 1;
    push(5, {19'd0, c}, 16'd0);
    fa = fb; ia = ib; pa = pb; oa = '0;
    for (int i = 0; i < p * rs; i++) begin push(0, mem_f(fa), 16'd0); fa++; end
    for (int col = 0; col < cols; col++) begin
      for (int i = 0; i < (col == 0 ? rs : 1); i++) begin push(1, mem_f(ia), 16'd0); ia++; end
      for (int i = 0; i < (c[12] ? q : p); i++) begin push(2, mem_f(pa), 16'd0); pa++; end
      if (c[12]) for (int i = 0; i < p; i++) begin push(3, mem_f(pa), 16'd0); pa++; end
      for (int i = 0; i < (c[12] ? q : p); i++) begin push(4, 32'h0B00_0000 + 32'(oa), ob + oa); oa++; end
    end
  endtask
  always @(posedge clk) rd_data <= rd_en ? mem_f(rd_addr) : 32'hDEAD_BEEF;
  always @(negedge clk) if (!rst) begin
    if (rd_en) n_rd++;
    if (filter_valid) n_fv++;
    if (done) n_done++;
    if (pe_en) see(5, {19'd0, pe_config}, 16'd0);
    if (filter_valid && filter_ready) begin n_fhs++; see(0, filter, 16'd0); end
    if (ifmap_valid && ifmap_ready) begin n_ihs++; see(1, ifmap, 16'd0); end
    if (depthwise_ipsum_valid && depthwise_ipsum_ready) see(2, depthwise_ipsum, 16'd0);
    if (pointwise_ipsum_valid && pointwise_ipsum_ready) see(3, pointwise_ipsum, 16'd0);
    if (wr_en) begin
      n_wr++;
      see(4, wr_data, wr_addr);
      chk("wr_only_on_valid", 64'(opsum_valid), 64'd1);
    end
  end
  initial begin
    logic a;
    int g;
    g = 0;
    forever begin
      @(negedge clk);
      a = wr_en;
      @(posedge clk);
      #1;
      if (a) ok_k++;
      opsum = 32'h0B00_0000 + 32'(ok_k);
      opsum_valid = (ov_mode == 0) || (g % 4 != 1);
      g++;
    end
  end
  task automatic launch(input logic [12:0] c, input logic [15:0] fb, ib, pb, ob);
    cfg = c; filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
    gen(c, fb, ib, pb, ob);
    n_fhs = 0; n_ihs = 0; n_wr = 0; n_rd = 0; n_done = 0; n_fv = 0; ok_k = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_within_budget", 64'(i < 3000), 64'd1);
    chk("busy_low_at_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("single_done_pulse", 64'(n_done), 64'd1);
  endtask
  initial begin
    logic [31:0] v;
    int i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {53'd0, busy, done, rd_en, wr_en, pe_en, filter_valid, ifmap_valid,
        depthwise_ipsum_valid, pointwise_ipsum_valid, opsum_ready, |pe_config}, 64'd0);
    chk("rst_addr", {32'd0, rd_addr, wr_addr}, 64'd0);
    chk("rst_data", {filter | ifmap | depthwise_ipsum | pointwise_ipsum, wr_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    launch(CA, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
    @(posedge clk); #1;
    cfg = CB; filter_base = 16'h0900; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("t1_filter_words", 64'(n_fhs), 64'd6);
    chk("t1_filter_valid_cycles", 64'(n_fv), 64'd6);
    chk("t1_writes", 64'(n_wr), 64'd2);
    launch(CD, 16'h1000, 16'h2000, 16'hFFFE, 16'hFFFC);
    wait_done();
    chk("dw_writes", 64'(n_wr), 64'd8);
    chk("dw_ifmap_words", 64'(n_ihs), 64'd4);
    launch(CA, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (filter_valid) break;
    end
    chk("bp_first_filter", 64'(i < 100), 64'd1);
    repeat (3) @(posedge clk);
    #1 filter_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v = filter;
    chk("bp_word2_value", {31'd0, filter_valid, v}, {31'd0, 1'b1, mem_f(16'h0102)});
    chk("bp_no_rd", 64'(rd_en), 64'd0);
    repeat (4) begin
      @(negedge clk);
      chk("bp_stable", {31'd0, filter_valid, filter}, {31'd0, 1'b1, v});
      chk("bp_no_rd", 64'(rd_en), 64'd0);
    end
    @(posedge clk); #1;
    filter_ready = 1'b1;
    wait_done();
    chk("bp_filter_words", 64'(n_fhs), 64'd6);
    chk("bp_reads", 64'(n_rd), 64'd11);
`ifdef PE_DRV_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd5);
`endif
    ov_mode = 1;
    launch(CE, 16'h0700, 16'h0710, 16'h0720, 16'h0500);
    wait_done();
    chk("gap_writes", 64'(n_wr), 64'd3);
    ov_mode = 0;
    launch(CA, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifmap_valid) break;
    end
    chk("rst_mid_reach_ifmap", 64'(i < 200), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {56'd0, busy, done, rd_en, wr_en, filter_valid, ifmap_valid,
        depthwise_ipsum_valid, pointwise_ipsum_valid}, 64'd0);
    sb.delete();
    n_done = 0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("rst_mid_no_done", {62'd0, busy, 1'b0} | 64'(n_done), 64'd0);
    launch(CA, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    wait_done();
    chk("post_rst_writes", 64'(n_wr), 64'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1);
  end
endmodule
